// File: rtl/radar_frame_parser_pkg.sv
// Shared constants and types for the radar telemetry frame parser ("AAA,DDD#" frames of 7-bit ASCII).
package radar_frame_parser_pkg;

  localparam int unsigned CHAR_W    = 7;
  localparam int unsigned DIGIT_W   = 4;
  localparam int unsigned NDIG      = 3;
  localparam int unsigned BCD_W     = NDIG * DIGIT_W;
  localparam int unsigned FRAME_LEN = 8;
  localparam int unsigned STATE_W   = $clog2(FRAME_LEN) + 1;
  localparam int unsigned STAT_W    = 8;

  localparam logic [CHAR_W-1:0] ASC_0    = 7'h30;
  localparam logic [CHAR_W-1:0] ASC_9    = 7'h39;
  localparam logic [CHAR_W-1:0] ASC_VIRG = 7'h2C;
  localparam logic [CHAR_W-1:0] ASC_FIM  = 7'h23;

  // Codes double as the frame position so db_estado reads as "chars accepted so far".
  typedef enum logic [STATE_W-1:0] {
    ST_D0     = STATE_W'(0),
    ST_D1     = STATE_W'(1),
    ST_D2     = STATE_W'(2),
    ST_SEP    = STATE_W'(3),
    ST_D4     = STATE_W'(4),
    ST_D5     = STATE_W'(5),
    ST_D6     = STATE_W'(6),
    ST_END    = STATE_W'(7),
    ST_RESYNC = STATE_W'(8)
  } state_e;

  typedef struct packed {
    logic [BCD_W-1:0] angulo;
    logic [BCD_W-1:0] distancia;
  } frame_t;

  function automatic logic is_digit(input logic [CHAR_W-1:0] c);
    return (c >= ASC_0) && (c <= ASC_9);
  endfunction

  // Mid-frame states where the inter-char timer is armed.
  function automatic logic in_frame(input state_e s);
    return (s >= ST_D1) && (s <= ST_END);
  endfunction

endpackage

// File: rtl/radar_frame_parser_if.sv
// Char-in / frame-out bus of the radar frame parser; counters exist only with RADAR_FRAME_STATS_EN.
interface radar_frame_parser_if;
  import radar_frame_parser_pkg::*;

  logic [CHAR_W-1:0]  dado_rx;
  logic               pronto_rx;
  logic [BCD_W-1:0]   angulo;
  logic [BCD_W-1:0]   distancia;
  logic               pronto_frame;
  logic               erro_frame;
  logic [STATE_W-1:0] db_estado;
`ifdef RADAR_FRAME_STATS_EN
  logic [STAT_W-1:0]  n_frames_ok;
  logic [STAT_W-1:0]  n_frames_err;
`endif

  modport master (
    output dado_rx, pronto_rx,
    input  angulo, distancia, pronto_frame, erro_frame, db_estado
`ifdef RADAR_FRAME_STATS_EN
    , input n_frames_ok, n_frames_err
`endif
  );

  modport slave (
    input  dado_rx, pronto_rx,
    output angulo, distancia, pronto_frame, erro_frame, db_estado
`ifdef RADAR_FRAME_STATS_EN
    , output n_frames_ok, n_frames_err
`endif
  );

endinterface

// File: rtl/radar_frame_parser_timer.sv
// Modulo-M counter with sync clear and enable; fim_c flags the terminal count M-1.
module radar_frame_parser_timer #(
  parameter int unsigned M = 2_000_000,
  parameter int unsigned N = 21
) (
  input  logic clock,
  input  logic reset,
  input  logic zera_s_i,
  input  logic conta_i,
  output logic fim_c
);

  logic [N-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (zera_s_i) begin
      cnt_d = '0;
    end else if (conta_i) begin
      cnt_d = (cnt_q == N'(M - 1)) ? '0 : cnt_q + N'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign fim_c = (cnt_q == N'(M - 1));

endmodule

// File: rtl/radar_frame_parser.sv
// Parses "AAA,DDD#" ASCII frames into BCD angle/distance with good/error pulses.
// Optional frame counters when RADAR_FRAME_STATS_EN is defined.
module radar_frame_parser
  import radar_frame_parser_pkg::*;
#(
  parameter int unsigned TIMEOUT = 2_000_000,
  parameter int unsigned TW      = 21
) (
  input  logic                 clock,
  input  logic                 reset,
  radar_frame_parser_if.slave  bus
);

  state_e             state_q, state_d;
  frame_t             shadow_q, shadow_d;
  frame_t             out_q, out_d;
  logic               ok_q, ok_d;
  logic               err_q, err_d;
  logic               timer_fim_c;
  logic               timeout_c;
  logic [CHAR_W-1:0]  ch;
  logic [DIGIT_W-1:0] nib;

  assign ch  = bus.dado_rx;
  assign nib = bus.dado_rx[DIGIT_W-1:0];

  // Any received char restarts the gap measurement; outside a frame the timer idles at zero.
  radar_frame_parser_timer #(
    .M (TIMEOUT),
    .N (TW)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .zera_s_i (bus.pronto_rx || !in_frame(state_q)),
    .conta_i  (in_frame(state_q)),
    .fim_c    (timer_fim_c)
  );

  assign timeout_c = timer_fim_c && in_frame(state_q);

  // Next-state, shadow capture and pulse generation; a char always beats a same-cycle timeout.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    out_d    = out_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;

    if (bus.pronto_rx) begin
      unique case (state_q)
        ST_D0, ST_D1, ST_D2, ST_D4, ST_D5, ST_D6: begin
          if (is_digit(ch)) begin
            unique case (state_q)
              ST_D0:   shadow_d.angulo[2*DIGIT_W +: DIGIT_W]    = nib;
              ST_D1:   shadow_d.angulo[DIGIT_W +: DIGIT_W]      = nib;
              ST_D2:   shadow_d.angulo[0 +: DIGIT_W]            = nib;
              ST_D4:   shadow_d.distancia[2*DIGIT_W +: DIGIT_W] = nib;
              ST_D5:   shadow_d.distancia[DIGIT_W +: DIGIT_W]   = nib;
              default: shadow_d.distancia[0 +: DIGIT_W]         = nib;
            endcase
            state_d = state_e'(state_q + STATE_W'(1));
          end else begin
            err_d   = 1'b1;
            state_d = (ch == ASC_FIM) ? ST_D0 : ST_RESYNC;
          end
        end
        ST_SEP: begin
          if (ch == ASC_VIRG) begin
            state_d = ST_D4;
          end else begin
            err_d   = 1'b1;
            state_d = (ch == ASC_FIM) ? ST_D0 : ST_RESYNC;
          end
        end
        ST_END: begin
          if (ch == ASC_FIM) begin
            out_d   = shadow_q;
            ok_d    = 1'b1;
            state_d = ST_D0;
          end else begin
            err_d   = 1'b1;
            state_d = ST_RESYNC;
          end
        end
        ST_RESYNC: begin
          if (ch == ASC_FIM) state_d = ST_D0;
        end
        default: begin
          state_d = ST_D0;
        end
      endcase
    end else if (timeout_c) begin
      err_d   = 1'b1;
      state_d = ST_D0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_D0;
      shadow_q <= '0;
      out_q    <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
    end
  end

  assign bus.angulo       = out_q.angulo;
  assign bus.distancia    = out_q.distancia;
  assign bus.pronto_frame = ok_q;
  assign bus.erro_frame   = err_q;
  assign bus.db_estado    = state_q;

`ifdef RADAR_FRAME_STATS_EN
  logic [STAT_W-1:0] n_ok_q, n_ok_d;
  logic [STAT_W-1:0] n_err_q, n_err_d;

  // Counters step on the same edge that raises the matching pulse; natural 8-bit wrap.
  always_comb begin
    n_ok_d  = n_ok_q  + STAT_W'(ok_d);
    n_err_d = n_err_q + STAT_W'(err_d);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      n_ok_q  <= '0;
      n_err_q <= '0;
    end else begin
      n_ok_q  <= n_ok_d;
      n_err_q <= n_err_d;
    end
  end

  assign bus.n_frames_ok  = n_ok_q;
  assign bus.n_frames_err = n_err_q;
`endif

endmodule
